// File: rtl/vga_scan_gen_if.sv
// Canvas coordinate and VGA timing bus between vga_scan_gen and the sprite modules.
// frame_count exists only when FRAME_COUNT_EN is defined.
interface vga_scan_gen_if;
    logic       pixel_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic       frame_start;
`ifdef FRAME_COUNT_EN
    logic [7:0] frame_count;
`endif

    modport master (
        output pixel_tick, x, y, hsync, vsync, active, frame_start
`ifdef FRAME_COUNT_EN
        , frame_count
`endif
    );

    modport slave (
        input pixel_tick, x, y, hsync, vsync, active, frame_start
`ifdef FRAME_COUNT_EN
        , frame_count
`endif
    );
endinterface

// File: rtl/vga_scan_gen.sv
// 640x480@60 VGA scan generator driving the 160x120 canvas bus (x, y) with sync/active
// delayed to match registered sprite outputs. Optional feature macro: FRAME_COUNT_EN.
module vga_scan_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SCALE_SHIFT = 2,
    parameter int PIPE_DELAY  = 1
) (
    input  logic            clk,
    input  logic            rst,
    vga_scan_gen_if.master  bus
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = $clog2(CLK_DIV);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_hcount;
    logic [9:0]       r_vcount;
    logic             r_tick;
    logic             r_frame_start;

    logic w_adv;
    logic w_h_wrap;
    logic w_v_wrap;
    logic w_active_raw;
    logic w_hsync_raw;
    logic w_vsync_raw;

    assign w_adv    = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_h_wrap = (r_hcount == 10'(H_TOTAL - 1));
    assign w_v_wrap = (r_vcount == 10'(V_TOTAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div         <= '0;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_tick        <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_adv ? '0 : r_div + DIV_W'(1);
            r_tick        <= w_adv;
            // Pulse lands in the same clk the counters first read (0,0).
            r_frame_start <= w_adv && w_h_wrap && w_v_wrap;
            if (w_adv) begin
                if (w_h_wrap) begin
                    r_hcount <= '0;
                    r_vcount <= w_v_wrap ? '0 : r_vcount + 10'd1;
                end else begin
                    r_hcount <= r_hcount + 10'd1;
                end
            end
        end
    end

    assign w_active_raw = (r_hcount < 10'(H_VISIBLE)) && (r_vcount < 10'(V_VISIBLE));
    assign w_hsync_raw  = !((r_hcount >= 10'(HS_START)) && (r_hcount < 10'(HS_END)));
    assign w_vsync_raw  = !((r_vcount >= 10'(VS_START)) && (r_vcount < 10'(VS_END)));

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign bus.hsync  = w_hsync_raw;
            assign bus.vsync  = w_vsync_raw;
            assign bus.active = w_active_raw;
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] r_hs_dly;
            logic [PIPE_DELAY-1:0] r_vs_dly;
            logic [PIPE_DELAY-1:0] r_act_dly;

            // Free-running shift, not gated by the pixel tick.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_hs_dly  <= '1;
                    r_vs_dly  <= '1;
                    r_act_dly <= '0;
                end else begin
                    r_hs_dly[0]  <= w_hsync_raw;
                    r_vs_dly[0]  <= w_vsync_raw;
                    r_act_dly[0] <= w_active_raw;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        r_hs_dly[i]  <= r_hs_dly[i-1];
                        r_vs_dly[i]  <= r_vs_dly[i-1];
                        r_act_dly[i] <= r_act_dly[i-1];
                    end
                end
            end

            assign bus.hsync  = r_hs_dly[PIPE_DELAY-1];
            assign bus.vsync  = r_vs_dly[PIPE_DELAY-1];
            assign bus.active = r_act_dly[PIPE_DELAY-1];
        end
    endgenerate

`ifdef FRAME_COUNT_EN
    logic [7:0] r_frame_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_count <= '0;
        end else if (w_adv && w_h_wrap && w_v_wrap) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign bus.frame_count = r_frame_count;
`endif

    assign bus.pixel_tick  = r_tick;
    assign bus.frame_start = r_frame_start;
    assign bus.x           = r_hcount >> SCALE_SHIFT;
    assign bus.y           = r_vcount >> SCALE_SHIFT;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: one full-size instance plus three shrunken-timing instances
// (PIPE_DELAY 1, 3, 0) checked every clk against an arithmetic model of the scan.
module tb_vga_scan_gen;

    typedef struct packed {
        int d;  int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb; int sh; int pd;
    } cfg_t;

    typedef struct packed {
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       act;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    localparam cfg_t CFG_A = '{d:4, hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, sh:2, pd:1};
    localparam cfg_t CFG_B = '{d:2, hv:6, hf:2, hs:3, hb:1, vv:4, vf:1, vs:2, vb:1, sh:1, pd:1};
    localparam cfg_t CFG_C = '{d:2, hv:6, hf:2, hs:3, hb:1, vv:4, vf:1, vs:2, vb:1, sh:1, pd:3};
    localparam cfg_t CFG_D = '{d:2, hv:6, hf:2, hs:3, hb:1, vv:4, vf:1, vs:2, vb:1, sh:1, pd:0};
    localparam int RUN_CLKS = 52000;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c, rst_d;
    int   k_a, k_b, k_c, k_d;
    int   total = 0;
    int   bad   = 0;
    logic run   = 1'b0;

    always #5 clk = ~clk;

    vga_scan_gen_if if_a();
    vga_scan_gen_if if_b();
    vga_scan_gen_if if_c();
    vga_scan_gen_if if_d();

    vga_scan_gen u_a (.clk(clk), .rst(rst_a), .bus(if_a));
    vga_scan_gen #(.CLK_DIV(2), .H_VISIBLE(6), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
                   .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SCALE_SHIFT(1),
                   .PIPE_DELAY(1)) u_b (.clk(clk), .rst(rst_b), .bus(if_b));
    vga_scan_gen #(.CLK_DIV(2), .H_VISIBLE(6), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
                   .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SCALE_SHIFT(1),
                   .PIPE_DELAY(3)) u_c (.clk(clk), .rst(rst_c), .bus(if_c));
    vga_scan_gen #(.CLK_DIV(2), .H_VISIBLE(6), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
                   .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SCALE_SHIFT(1),
                   .PIPE_DELAY(0)) u_d (.clk(clk), .rst(rst_d), .bus(if_d));

    // Clocks elapsed since each instance last left reset.
    always @(posedge clk or posedge rst_a) if (rst_a) k_a <= 0; else k_a <= k_a + 1;
    always @(posedge clk or posedge rst_b) if (rst_b) k_b <= 0; else k_b <= k_b + 1;
    always @(posedge clk or posedge rst_c) if (rst_c) k_c <= 0; else k_c <= k_c + 1;
    always @(posedge clk or posedge rst_d) if (rst_d) k_d <= 0; else k_d <= k_d + 1;

    // Scan position after k clks: P pixels elapsed, sync/active seen pd clks late.
    function automatic exp_t model(input cfg_t c, input int k);
        exp_t e;
        int ht, vt, frame, p, h, v, p2, h2, v2;
        ht    = c.hv + c.hf + c.hs + c.hb;
        vt    = c.vv + c.vf + c.vs + c.vb;
        frame = ht * vt;
        p     = k / c.d;
        h     = p % ht;
        v     = (p / ht) % vt;
        e.tick = (k > 0) && (k % c.d == 0);
        e.fs   = e.tick && (p % frame == 0);
        e.fc   = 8'((p / frame) % 256);
        e.x    = 10'(h >> c.sh);
        e.y    = 10'(v >> c.sh);
        if (k >= c.pd) begin
            p2    = (k - c.pd) / c.d;
            h2    = p2 % ht;
            v2    = (p2 / ht) % vt;
            e.act = (h2 < c.hv) && (v2 < c.vv);
            e.hs  = !((h2 >= c.hv + c.hf) && (h2 < c.hv + c.hf + c.hs));
            e.vs  = !((v2 >= c.vv + c.vf) && (v2 < c.vv + c.vf + c.vs));
        end else begin
            e.act = 1'b0;
            e.hs  = 1'b1;
            e.vs  = 1'b1;
        end
        return e;
    endfunction

    task automatic cmp(input string nm, input int k, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s k=%0d got=%0d want=%0d", nm, k, got, want);
        end
    endtask

    task automatic check_dut(input string tag, input cfg_t c, input int k, input logic tick,
                             input logic [9:0] x, input logic [9:0] y, input logic hs,
                             input logic vs, input logic act, input logic fs, input logic [7:0] fc);
        exp_t e;
        e = model(c, k);
        cmp({tag, ".pixel_tick"}, k, int'(tick), int'(e.tick));
        cmp({tag, ".x"}, k, int'(x), int'(e.x));
        cmp({tag, ".y"}, k, int'(y), int'(e.y));
        cmp({tag, ".hsync"}, k, int'(hs), int'(e.hs));
        cmp({tag, ".vsync"}, k, int'(vs), int'(e.vs));
        cmp({tag, ".active"}, k, int'(act), int'(e.act));
        cmp({tag, ".frame_start"}, k, int'(fs), int'(e.fs));
`ifdef FRAME_COUNT_EN
        cmp({tag, ".frame_count"}, k, int'(fc), int'(e.fc));
`else
        if (fc != 8'd0) cmp({tag, ".frame_count_tie"}, k, int'(fc), 0);
`endif
    endtask

`ifdef FRAME_COUNT_EN
    wire [7:0] fc_a = if_a.frame_count;
    wire [7:0] fc_b = if_b.frame_count;
    wire [7:0] fc_c = if_c.frame_count;
    wire [7:0] fc_d = if_d.frame_count;
`else
    wire [7:0] fc_a = 8'd0;
    wire [7:0] fc_b = 8'd0;
    wire [7:0] fc_c = 8'd0;
    wire [7:0] fc_d = 8'd0;
`endif

    always @(negedge clk) begin
        if (run) begin
            check_dut("A", CFG_A, k_a, if_a.pixel_tick, if_a.x, if_a.y, if_a.hsync, if_a.vsync, if_a.active, if_a.frame_start, fc_a);
            check_dut("B", CFG_B, k_b, if_b.pixel_tick, if_b.x, if_b.y, if_b.hsync, if_b.vsync, if_b.active, if_b.frame_start, fc_b);
            check_dut("C", CFG_C, k_c, if_c.pixel_tick, if_c.x, if_c.y, if_c.hsync, if_c.vsync, if_c.active, if_c.frame_start, fc_c);
            check_dut("D", CFG_D, k_d, if_d.pixel_tick, if_d.x, if_d.y, if_d.hsync, if_d.vsync, if_d.active, if_d.frame_start, fc_d);
        end
    end

    task automatic wait_a(input int target);
        int guard = 0;
        while (k_a < target && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (k_a != target) cmp("wait_a_timeout", k_a, k_a, target);
    endtask

    task automatic wait_b(input int target);
        int guard = 0;
        while (k_b < target && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (k_b != target) cmp("wait_b_timeout", k_b, k_b, target);
    endtask

    task automatic seq_a;
        wait_a(4);     cmp("A.tick_k4", 4, int'(if_a.pixel_tick), 1);  cmp("A.x_k4", 4, int'(if_a.x), 0);
        wait_a(5);     cmp("A.tick_k5", 5, int'(if_a.pixel_tick), 0);
        wait_a(12);    cmp("A.tick_k12", 12, int'(if_a.pixel_tick), 1); cmp("A.x_k12", 12, int'(if_a.x), 0);
        wait_a(15);    cmp("D.hsync_k15", 15, int'(if_d.hsync), 1);
        wait_a(16);    cmp("D.hsync_k16", 16, int'(if_d.hsync), 0);
        wait_a(18);    cmp("C.hsync_k18", 18, int'(if_c.hsync), 1);
        wait_a(19);    cmp("C.hsync_k19", 19, int'(if_c.hsync), 0);
        wait_a(2624);  cmp("A.hsync_at656", 2624, int'(if_a.hsync), 1);
        wait_a(2625);  cmp("A.hsync_fall", 2625, int'(if_a.hsync), 0);
        wait_a(3008);  cmp("A.hsync_last_low", 3008, int'(if_a.hsync), 0);
        wait_a(3009);  cmp("A.hsync_rise", 3009, int'(if_a.hsync), 1);
        wait_a(35199); cmp("A.x_h799", 35199, int'(if_a.x), 199);
        wait_a(35200); cmp("A.y_v11", 35200, int'(if_a.y), 2);   cmp("A.x_wrap", 35200, int'(if_a.x), 0);
    endtask

    task automatic seq_b;
        wait_b(300);
        @(posedge clk);
        #2 rst_b = 1'b1;
        #1;
        cmp("B.rst_tick", 0, int'(if_b.pixel_tick), 0);
        cmp("B.rst_x", 0, int'(if_b.x), 0);
        cmp("B.rst_y", 0, int'(if_b.y), 0);
        cmp("B.rst_hsync", 0, int'(if_b.hsync), 1);
        cmp("B.rst_vsync", 0, int'(if_b.vsync), 1);
        cmp("B.rst_active", 0, int'(if_b.active), 0);
        cmp("B.rst_fs", 0, int'(if_b.frame_start), 0);
        repeat (3) @(posedge clk);
        #2 rst_b = 1'b0;
        wait_b(191);   cmp("B.fs_before", 191, int'(if_b.frame_start), 0);
        wait_b(192);   cmp("B.fs_first", 192, int'(if_b.frame_start), 1);
        wait_b(193);   cmp("B.fs_one_clk", 193, int'(if_b.frame_start), 0);
    endtask

    initial begin
        exp_t e;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;

        // Hand-computed points that pin the model itself.
        e = model(CFG_A, 12);             cmp("M.tick12", 12, int'(e.tick), 1);
        e = model(CFG_A, 2624);           cmp("M.hs2624", 2624, int'(e.hs), 1);
        e = model(CFG_A, 2625);           cmp("M.hs2625", 2625, int'(e.hs), 0);
        e = model(CFG_A, 3009);           cmp("M.hs3009", 3009, int'(e.hs), 1);
        e = model(CFG_A, 1535360);        cmp("M.act_l479", 1535360, int'(e.act), 1);
        e = model(CFG_A, 1535361);        cmp("M.act_drop", 1535361, int'(e.act), 0);
                                          cmp("M.x160", 1535361, int'(e.x), 160);
        e = model(CFG_A, 1568000);        cmp("M.vs_pre", 1568000, int'(e.vs), 1);
        e = model(CFG_A, 1568001);        cmp("M.vs_fall", 1568001, int'(e.vs), 0);
        e = model(CFG_A, 1574400);        cmp("M.vs_last", 1574400, int'(e.vs), 0);
        e = model(CFG_A, 1574401);        cmp("M.vs_rise", 1574401, int'(e.vs), 1);
        e = model(CFG_A, 1679999);        cmp("M.fs_pre", 1679999, int'(e.fs), 0);
        e = model(CFG_A, 1680000);        cmp("M.fs", 1680000, int'(e.fs), 1);
                                          cmp("M.fc1", 1680000, int'(e.fc), 1);
        e = model(CFG_A, 3360000);        cmp("M.fc2", 3360000, int'(e.fc), 2);
        e = model(CFG_C, 48960);          cmp("M.fc255", 48960, int'(e.fc), 255);
        e = model(CFG_C, 49152);          cmp("M.fc_wrap", 49152, int'(e.fc), 0);

        run = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;

        fork
            seq_a();
            seq_b();
        join

`ifdef FRAME_COUNT_EN
        wait_a(48960); cmp("C.fc255", 48960, int'(if_c.frame_count), 255);
        wait_a(49152); cmp("C.fc_wrap", 49152, int'(if_c.frame_count), 0);
`endif
        wait_a(RUN_CLKS);
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
